// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   WIDTH    : default operand width (HI and LO are each WIDTH bits)
//   OP_*     : req_op encoding; bit 0 selects divide, bit 1 selects signed
//   state_e  : control FSM states
package muldiv_unit_pkg;

    localparam int unsigned WIDTH = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response channel of the multiply/divide unit.
//   req_valid/req_ready/req_op/req_a/req_b : operand request handshake
//   rsp_valid/rsp_ready/rsp_hi/rsp_lo/rsp_div0 : HI/LO result handshake
//   busy : unit is not idle
// master drives requests and consumes responses; slave is the unit.
interface muldiv_unit_if #(
    parameter int unsigned Width = muldiv_unit_pkg::WIDTH
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [Width-1:0] req_a;
    logic [Width-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [Width-1:0] rsp_hi;
    logic [Width-1:0] rsp_lo;
    logic             rsp_div0;
    logic             busy;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_div0, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_div0, busy
    );
endinterface

// File: rtl/muldiv_signfix.sv
// Sign handling for signed MULT/DIV, purely combinational.
//   signed_i, a_i, b_i        : raw request operands and signed-op select
//   a_mag_o, b_mag_o          : operand magnitudes fed to the unsigned core
//   sign_a_o, sign_b_o        : operand signs (0 for unsigned ops)
//   is_div_i, neg_a_i, neg_b_i: latched op kind and operand signs
//   hi_i, lo_i / hi_o, lo_o   : unsigned core result / sign-corrected result
module muldiv_signfix #(
    parameter int unsigned Width = 32
) (
    input  logic             signed_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic [Width-1:0] a_mag_o,
    output logic [Width-1:0] b_mag_o,
    output logic             sign_a_o,
    output logic             sign_b_o,
    input  logic             is_div_i,
    input  logic             neg_a_i,
    input  logic             neg_b_i,
    input  logic [Width-1:0] hi_i,
    input  logic [Width-1:0] lo_i,
    output logic [Width-1:0] hi_o,
    output logic [Width-1:0] lo_o
);
    logic [2*Width-1:0] prod;
    logic               neg_res;

    assign sign_a_o = signed_i & a_i[Width-1];
    assign sign_b_o = signed_i & b_i[Width-1];
    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    assign a_mag_o  = sign_a_o ? -a_i : a_i;
    assign b_mag_o  = sign_b_o ? -b_i : b_i;

    assign prod    = {hi_i, lo_i};
    assign neg_res = neg_a_i ^ neg_b_i;

    always_comb begin
        hi_o = hi_i;
        lo_o = lo_i;
        if (is_div_i) begin
            // Quotient takes the XOR of signs; remainder follows the dividend.
            lo_o = neg_res ? -lo_i : lo_i;
            hi_o = neg_a_i ? -hi_i : hi_i;
        end else if (neg_res) begin
            {hi_o, lo_o} = -prod;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiplier and restoring divider
// sharing one 2*Width accumulator; one result step per cycle.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : muldiv_unit_if slave (request, response, busy)
// Define MULDIV_SIGNED_EN to honour req_op[1] (MULT/DIV) via muldiv_signfix;
// otherwise every operation is unsigned.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned Width = WIDTH
) (
    input logic           clk,
    input logic           rst_n,
    muldiv_unit_if.slave  bus
);
    localparam int unsigned CntW = $clog2(Width + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(Width);

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*Width-1:0] acc_q, acc_d;
    logic [Width-1:0]   b_q, b_d;
    logic [Width-1:0]   a_raw_q, a_raw_d;
    logic               is_div_q, is_div_d;
    logic               div0_q, div0_d;
    logic [Width-1:0]   rsp_hi_q, rsp_hi_d;
    logic [Width-1:0]   rsp_lo_q, rsp_lo_d;
    logic               rsp_div0_q, rsp_div0_d;

    logic [Width-1:0]   a_mag, b_mag;
    logic [Width-1:0]   fin_hi, fin_lo;

`ifdef MULDIV_SIGNED_EN
    logic sign_a, sign_b;
    logic neg_a_q, neg_a_d, neg_b_q, neg_b_d;

    muldiv_signfix #(
        .Width (Width)
    ) u_signfix (
        .signed_i (bus.req_op[1]),
        .a_i      (bus.req_a),
        .b_i      (bus.req_b),
        .a_mag_o  (a_mag),
        .b_mag_o  (b_mag),
        .sign_a_o (sign_a),
        .sign_b_o (sign_b),
        .is_div_i (is_div_q),
        .neg_a_i  (neg_a_q),
        .neg_b_i  (neg_b_q),
        .hi_i     (acc_q[2*Width-1:Width]),
        .lo_i     (acc_q[Width-1:0]),
        .hi_o     (fin_hi),
        .lo_o     (fin_lo)
    );
`else
    logic unused_op_signed;
    assign unused_op_signed = bus.req_op[1];
    assign a_mag  = bus.req_a;
    assign b_mag  = bus.req_b;
    assign fin_hi = acc_q[2*Width-1:Width];
    assign fin_lo = acc_q[Width-1:0];
`endif

    // Multiply step: acc = {product high, remaining multiplier bits}.
    logic [Width:0]     mul_sum;
    logic [2*Width-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*Width-1:Width]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[Width-1:1]};

    // Divide step: acc = {partial remainder, dividend bits shifting into quotient bits}.
    logic [Width:0]     rem_sh, trial;
    logic [2*Width-1:0] div_next;
    assign rem_sh   = {acc_q[2*Width-1:Width], acc_q[Width-1]};
    assign trial    = rem_sh - {1'b0, b_q};
    assign div_next = trial[Width] ? {rem_sh[Width-1:0], acc_q[Width-2:0], 1'b0}
                                   : {trial[Width-1:0], acc_q[Width-2:0], 1'b1};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        b_d        = b_q;
        a_raw_d    = a_raw_q;
        is_div_d   = is_div_q;
        div0_d     = div0_q;
        rsp_hi_d   = rsp_hi_q;
        rsp_lo_d   = rsp_lo_q;
        rsp_div0_d = rsp_div0_q;
`ifdef MULDIV_SIGNED_EN
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    acc_d    = {{Width{1'b0}}, a_mag};
                    b_d      = b_mag;
                    a_raw_d  = bus.req_a;
                    is_div_d = bus.req_op[0];
                    div0_d   = bus.req_op[0] && (bus.req_b == '0);
                    cnt_d    = '0;
                    state_d  = StRun;
`ifdef MULDIV_SIGNED_EN
                    neg_a_d  = sign_a;
                    neg_b_d  = sign_b;
`endif
                end
            end
            StRun: begin
                // Width steps, then one cycle to register the corrected result.
                if (cnt_q == LastCnt) begin
                    rsp_hi_d   = div0_q ? a_raw_q : fin_hi;
                    rsp_lo_d   = div0_q ? '1 : fin_lo;
                    rsp_div0_d = div0_q;
                    state_d    = StDone;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            b_q        <= '0;
            a_raw_q    <= '0;
            is_div_q   <= 1'b0;
            div0_q     <= 1'b0;
            rsp_hi_q   <= '0;
            rsp_lo_q   <= '0;
            rsp_div0_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            b_q        <= b_d;
            a_raw_q    <= a_raw_d;
            is_div_q   <= is_div_d;
            div0_q     <= div0_d;
            rsp_hi_q   <= rsp_hi_d;
            rsp_lo_q   <= rsp_lo_d;
            rsp_div0_q <= rsp_div0_d;
`ifdef MULDIV_SIGNED_EN
            neg_a_q    <= neg_a_d;
            neg_b_q    <= neg_b_d;
`endif
        end
    end

    // Gated by rst_n so the channel reads not-ready while reset is held.
    assign bus.req_ready = rst_n && (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.rsp_hi    = rsp_hi_q;
    assign bus.rsp_lo    = rsp_lo_q;
    assign bus.rsp_div0  = rsp_div0_q;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    muldiv_unit_if #(.Width(32)) mif ();

    muldiv_unit #(.Width(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a request and wait for acceptance; returns just after the accept edge.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int waited;
        waited = 0;
        while (!mif.req_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check_eq("accept_wait", 32'(waited < 100), 32'd1);
        mif.req_op    = op;
        mif.req_a     = a;
        mif.req_b     = b;
        mif.req_valid = 1'b1;
        @(posedge clk); #1;
        mif.req_valid = 1'b0;
        // Operands wiggling during RUN must be ignored.
        mif.req_a     = 32'hDEAD_BEEF;
        mif.req_b     = 32'h0000_1234;
    endtask

    task automatic wait_rsp(output int lat, output logic ready_seen);
        lat        = 0;
        ready_seen = 1'b0;
        while (!mif.rsp_valid && lat < 100) begin
            if (mif.req_ready || !mif.busy) ready_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_rsp();
        mif.rsp_ready = 1'b1;
        @(posedge clk); #1;
        mif.rsp_ready = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo, input logic exp_div0);
        int   lat;
        logic seen;
        start_op(op, a, b);
        wait_rsp(lat, seen);
        check_eq({tag, "_lat"}, 32'(lat), 32'd33);
        check_eq({tag, "_hi"}, mif.rsp_hi, exp_hi);
        check_eq({tag, "_lo"}, mif.rsp_lo, exp_lo);
        check_eq({tag, "_div0"}, 32'(mif.rsp_div0), 32'(exp_div0));
        check_eq({tag, "_ready_in_run"}, 32'(seen), 32'd0);
        finish_rsp();
        check_eq({tag, "_idle"}, 32'(mif.busy), 32'd0);
        check_eq({tag, "_held_lo"}, mif.rsp_lo, exp_lo);
    endtask

    initial begin
        int   lat;
        logic seen;
        logic [31:0] hold_hi, hold_lo;
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        mif.req_valid = 1'b0;
        mif.req_op    = OP_MULTU;
        mif.req_a     = '0;
        mif.req_b     = '0;
        mif.rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(mif.req_ready), 32'd0);
        check_eq("rst_valid", 32'(mif.rsp_valid), 32'd0);
        check_eq("rst_busy", 32'(mif.busy), 32'd0);
        check_eq("rst_hi", mif.rsp_hi, 32'd0);
        check_eq("rst_lo", mif.rsp_lo, 32'd0);
        check_eq("rst_div0", 32'(mif.rsp_div0), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_ready", 32'(mif.req_ready), 32'd1);

        run_check("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_check("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_check("multu_shift", OP_MULTU, 32'h1234_5678, 32'h10,
                  32'h0000_0001, 32'h2345_6780, 1'b0);
        run_check("divu_by1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0);
        run_check("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
`ifdef MULDIV_SIGNED_EN
        run_check("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_check("mult_m3_5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_check("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
`else
        run_check("div_m7_2_u", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0);
        run_check("mult_m3_5_u", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'd4, 32'hFFFF_FFF1, 1'b0);
        run_check("div_ovf_u", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
`endif

        // Stall in DONE with a second request pending.
        start_op(OP_MULTU, 32'd6, 32'd7);
        wait_rsp(lat, seen);
        check_eq("stall_lat", 32'(lat), 32'd33);
        hold_hi = 32'd0;
        hold_lo = 32'd42;
        mif.req_op    = OP_MULTU;
        mif.req_a     = 32'd2;
        mif.req_b     = 32'd9;
        mif.req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq("stall_valid", 32'(mif.rsp_valid), 32'd1);
            check_eq("stall_lo", mif.rsp_lo, hold_lo);
            check_eq("stall_hi", mif.rsp_hi, hold_hi);
        end
        mif.req_valid = 1'b0;
        finish_rsp();
        check_eq("stall_idle_ready", 32'(mif.req_ready), 32'd1);
        run_check("after_stall", OP_MULTU, 32'd2, 32'd9, 32'd0, 32'd18, 1'b0);

        // Reset in the middle of RUN.
        start_op(OP_MULTU, 32'hFFFF_FFFF, 32'h7);
        repeat (12) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(mif.rsp_valid), 32'd0);
        check_eq("midrst_busy", 32'(mif.busy), 32'd0);
        check_eq("midrst_hi", mif.rsp_hi, 32'd0);
        check_eq("midrst_lo", mif.rsp_lo, 32'd0);
        check_eq("midrst_ready", 32'(mif.req_ready), 32'd0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst_after_valid", 32'(mif.rsp_valid), 32'd0);
        run_check("multu_3_4", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
